// File: rtl/atm_session_ctrl.sv
// ATM session controller: per-account balance/PIN/lock tables, PIN authentication
// with retry lockout, multi-operation sessions with a withdrawal cap and idle timeout.
module atm_session_ctrl #(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 4,
    parameter int BAL_W        = 32,
    parameter int PIN_W        = 16,
    parameter int MAX_TRIES    = 3,
    parameter int WD_LIMIT     = 5000,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int BAL_STEP     = 1000,
    parameter int PIN_BASE     = 32'h1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_valid,
    input  logic [2:0]       operation,
    input  logic [BAL_W-1:0] amount,
    input  logic [PIN_W-1:0] new_pin,
    output logic             done,
    output logic             success,
    output logic [2:0]       err_code,
    output logic [BAL_W-1:0] balance,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AUTH = 3'd1;
    localparam logic [2:0] S_MENU = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;

    localparam logic [2:0] OP_BAL  = 3'd0;
    localparam logic [2:0] OP_WD   = 3'd1;
    localparam logic [2:0] OP_DEP  = 3'd2;
    localparam logic [2:0] OP_PIN  = 3'd3;
    localparam logic [2:0] OP_EXIT = 3'd4;

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_NOACC   = 3'd1;
    localparam logic [2:0] ERR_BADPIN  = 3'd2;
    localparam logic [2:0] ERR_LOCKED  = 3'd3;
    localparam logic [2:0] ERR_FUNDS   = 3'd4;
    localparam logic [2:0] ERR_LIMIT   = 3'd5;
    localparam logic [2:0] ERR_INVALID = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;

    localparam int FC_W  = $clog2(MAX_TRIES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [ACC_W:0]   ACC_LIM    = (ACC_W + 1)'(NUM_ACCOUNTS);
    localparam logic [BAL_W:0]   WD_LIM_X   = (BAL_W + 1)'(WD_LIMIT);
    localparam logic [FC_W-1:0]  TRIES_LIM  = FC_W'(MAX_TRIES);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

    logic [BAL_W-1:0] bal_r  [NUM_ACCOUNTS];
    logic [PIN_W-1:0] pin_r  [NUM_ACCOUNTS];
    logic [FC_W-1:0]  fail_r [NUM_ACCOUNTS];
    logic             lock_r [NUM_ACCOUNTS];

    logic [2:0]       state_r;
    logic             done_r;
    logic             success_r;
    logic [2:0]       err_r;
    logic [BAL_W-1:0] balance_r;

    logic [ACC_W-1:0] acc_r;
    logic [PIN_W-1:0] pin_in_r;
    logic [ACC_W-1:0] sess_r;
    logic [BAL_W-1:0] total_r;
    logic [TMO_W-1:0] tmo_r;
    logic [2:0]       op_r;
    logic [BAL_W-1:0] amt_r;
    logic [PIN_W-1:0] new_pin_r;

    logic             acc_ok_s;
    logic [ACC_W-1:0] idx_s;
    logic [FC_W-1:0]  fail_inc_s;
    logic [2:0]       auth_err_s;
    logic [BAL_W-1:0] cur_bal_s;
    logic [BAL_W:0]   sum_s;
    logic [BAL_W:0]   lim_s;
    logic [2:0]       exec_err_s;
    logic [BAL_W-1:0] new_bal_s;
    logic [BAL_W-1:0] new_total_s;

    assign done     = done_r;
    assign success  = success_r;
    assign err_code = err_r;
    assign balance  = balance_r;
    assign state    = state_r;

    // Authentication verdict for the latched card; out-of-range accounts are steered to index 0
    always_comb begin
        acc_ok_s   = ({1'b0, acc_r} < ACC_LIM);
        idx_s      = acc_ok_s ? acc_r : {ACC_W{1'b0}};
        fail_inc_s = fail_r[idx_s] + FC_W'(1);
        if (!acc_ok_s) begin
            auth_err_s = ERR_NOACC;
        end else if (lock_r[idx_s]) begin
            auth_err_s = ERR_LOCKED;
        end else if (pin_r[idx_s] != pin_in_r) begin
            auth_err_s = ERR_BADPIN;
        end else begin
            auth_err_s = ERR_OK;
        end
    end

    // Operation result for the latched request; sums carry one extra bit so nothing wraps
    always_comb begin
        cur_bal_s   = bal_r[sess_r];
        sum_s       = {1'b0, cur_bal_s} + {1'b0, amt_r};
        lim_s       = {1'b0, total_r} + {1'b0, amt_r};
        exec_err_s  = ERR_OK;
        new_bal_s   = cur_bal_s;
        new_total_s = total_r;
        case (op_r)
            OP_BAL, OP_PIN, OP_EXIT: begin
                exec_err_s = ERR_OK;
            end
            OP_WD: begin
                if (amt_r > cur_bal_s) begin
                    exec_err_s = ERR_FUNDS;
                end else if (lim_s > WD_LIM_X) begin
                    exec_err_s = ERR_LIMIT;
                end else begin
                    new_bal_s   = cur_bal_s - amt_r;
                    new_total_s = lim_s[BAL_W-1:0];
                end
            end
            OP_DEP: begin
                if (sum_s[BAL_W]) begin
                    exec_err_s = ERR_INVALID;
                end else begin
                    new_bal_s = sum_s[BAL_W-1:0];
                end
            end
            default: begin
                exec_err_s = ERR_INVALID;
            end
        endcase
    end

    // Session FSM, account tables and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal_r[i]  <= BAL_W'(BAL_STEP * (i + 1));
                pin_r[i]  <= PIN_W'(PIN_BASE + i);
                fail_r[i] <= {FC_W{1'b0}};
                lock_r[i] <= 1'b0;
            end
            state_r   <= S_IDLE;
            done_r    <= 1'b0;
            success_r <= 1'b0;
            err_r     <= ERR_OK;
            balance_r <= {BAL_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            pin_in_r  <= {PIN_W{1'b0}};
            sess_r    <= {ACC_W{1'b0}};
            total_r   <= {BAL_W{1'b0}};
            tmo_r     <= {TMO_W{1'b0}};
            op_r      <= 3'd0;
            amt_r     <= {BAL_W{1'b0}};
            new_pin_r <= {PIN_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        acc_r    <= acc_num;
                        pin_in_r <= pin;
                        state_r  <= S_AUTH;
                    end
                end
                S_AUTH: begin
                    done_r    <= 1'b1;
                    err_r     <= auth_err_s;
                    success_r <= (auth_err_s == ERR_OK);
                    if (auth_err_s == ERR_OK) begin
                        state_r       <= S_MENU;
                        sess_r        <= idx_s;
                        fail_r[idx_s] <= {FC_W{1'b0}};
                        total_r       <= {BAL_W{1'b0}};
                        balance_r     <= bal_r[idx_s];
                        tmo_r         <= {TMO_W{1'b0}};
                    end else begin
                        state_r <= S_IDLE;
                        if (auth_err_s == ERR_BADPIN) begin
                            fail_r[idx_s] <= fail_inc_s;
                            if (fail_inc_s >= TRIES_LIM) begin
                                lock_r[idx_s] <= 1'b1;
                            end
                        end
                    end
                end
                S_MENU: begin
                    // A request in the last idle cycle takes priority over the timeout
                    if (op_valid) begin
                        op_r      <= operation;
                        amt_r     <= amount;
                        new_pin_r <= new_pin;
                        tmo_r     <= {TMO_W{1'b0}};
                        state_r   <= S_EXEC;
                    end else if (tmo_r == TMO_LAST) begin
                        done_r    <= 1'b1;
                        success_r <= 1'b0;
                        err_r     <= ERR_TIMEOUT;
                        balance_r <= {BAL_W{1'b0}};
                        state_r   <= S_IDLE;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                S_EXEC: begin
                    done_r         <= 1'b1;
                    err_r          <= exec_err_s;
                    success_r      <= (exec_err_s == ERR_OK);
                    bal_r[sess_r]  <= new_bal_s;
                    total_r        <= new_total_s;
                    tmo_r          <= {TMO_W{1'b0}};
                    if (op_r == OP_PIN) begin
                        pin_r[sess_r] <= new_pin_r;
                    end
                    if (op_r == OP_EXIT) begin
                        balance_r <= {BAL_W{1'b0}};
                        state_r   <= S_IDLE;
                    end else begin
                        balance_r <= new_bal_s;
                        state_r   <= S_MENU;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Parametrised multi-operation ATM session controller: the next generation of the team's ATM FSM.
- Holds balance, PIN, fail-count and lock tables for NUM_ACCOUNTS accounts.
- Authenticates a card with retry lockout, then serves any number of operations per session until exit or idle timeout.
- Enforces a per-session cumulative withdrawal limit.
- All operations use an explicit start/op_valid → done handshake; the block sits between the front-end keypad/card logic and the display.

Parameters:
NUM_ACCOUNTS, 10, number of accounts (2..16)
ACC_W, 4, acc_num width; must satisfy 2**ACC_W >= NUM_ACCOUNTS
BAL_W, 32, balance and amount width (unsigned)
PIN_W, 16, PIN width
MAX_TRIES, 3, consecutive wrong PINs before account lock
WD_LIMIT, 5000, max cumulative withdrawal per session
TIMEOUT_CYC, 1000, idle MENU cycles before forced logout (>=2)
BAL_STEP, 1000, reset balance of account i = BAL_STEP*(i+1)
PIN_BASE, 16'h1000, reset PIN of account i = PIN_BASE+i

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  session request, sampled only in IDLE
acc_num  in  ACC_W  account number, sampled with start
pin  in  PIN_W  entered PIN, sampled with start
op_valid  in  1  operation request, sampled only in MENU
operation  in  3  0=balance 1=withdraw 2=deposit 3=change PIN 4=exit; 5-7 invalid
amount  in  BAL_W  withdraw/deposit amount, sampled with op_valid
new_pin  in  PIN_W  replacement PIN, sampled with op_valid
done  out  1  one-cycle completion pulse
success  out  1  result of the op flagged by done; holds until next done
err_code  out  3  0 ok, 1 no account, 2 bad PIN, 3 locked, 4 insufficient funds, 5 limit exceeded, 6 overflow/invalid op, 7 timeout
balance  out  BAL_W  balance of the session account; 0 outside a session
state  out  3  0 IDLE, 1 AUTH, 2 MENU, 3 EXEC

Behaviour:
- Reset (async, rst=0): state IDLE; done=0, success=0, err_code=0, balance=0. All tables reinitialised: balances and PINs per the BAL_STEP/PIN_BASE formulas, fail counts 0, locks clear; session withdrawal total cleared. Reset mid-session aborts the session with no done pulse.
- All outputs are registered.
- IDLE: start=1 at edge N → AUTH at N+1. AUTH resolves at the edge ending N+1, so done=1 at N+2.
- AUTH priority, highest first:
  - acc_num >= NUM_ACCOUNTS → err 1.
  - Account locked → err 3, even with the correct PIN.
  - PIN mismatch → err 2 and fail count +1; reaching MAX_TRIES sets lock.
  - Match → success=1, fail count cleared, withdrawal total cleared, state MENU, balance shows the account.
  - Every failure returns to IDLE.
- MENU: op_valid=1 at edge M → EXEC at M+1; done at M+2.
  - After balance/withdraw/deposit/change PIN, return to MENU; balance output is updated in the same cycle as done.
  - Exit → done with success=1, then IDLE.
- Withdraw: checks in order:
  - amount > balance → err 4.
  - total + amount > WD_LIMIT → err 5.
  - Otherwise subtract, add to total, success.
  - amount=0 succeeds with no change.
  - The limit compare uses BAL_W+1 bits, so no wrap.
- Deposit: if the BAL_W+1-bit sum overflows BAL_W → err 6 and balance unchanged; otherwise add.
- Change PIN: always succeeds and writes new_pin. The next session must use the new PIN.
- Invalid operation (5-7): err 6, stay in MENU.
- Balance query: success, no table change.
- Timeout:
  - Counter reloads on MENU entry and on each accepted op_valid.
  - After TIMEOUT_CYC consecutive MENU cycles without op_valid: done, success=0, err 7, IDLE.
  - op_valid in the final cycle wins over timeout.
- Ignored inputs: start outside IDLE; op_valid outside MENU, including during EXEC.
- done is never asserted on two consecutive cycles. success and err_code change only with done.

Test Plan:
1. Reset, then start acc 2 / pin 0x1002 → done at +2 with success=1, err 0, state MENU, balance=3000. Then op 0 → done, balance 3000.
2. Session acc 0 (1000): withdraw 600 → balance 400. Withdraw 500 → err 4. Deposit 4600 → 5000. Withdraw 4500 → err 5 (total 600+4500 > 5000). Withdraw 4400 → ok, balance 600.
3. Acc 5 with wrong PIN ×3 → err 2 each time. Fourth attempt with the correct PIN 0x1005 → err 3. rst pulse, then the correct PIN → success.
4. acc_num 12 → err 1. Acc 9: deposit 0xFFFF_FFFF → err 6, balance 10000. Operation 6 → err 6, still in MENU.
5. Acc 1: change PIN to 0xBEEF, exit → IDLE. start with 0x1001 → err 2; start with 0xBEEF → success.
6. Acc 3 in MENU, no op_valid for TIMEOUT_CYC cycles → err 7, IDLE. Repeat with op_valid on the final cycle → op executes, no timeout. Assert rst during EXEC → IDLE, no done, tables back to reset values.
